// File: rtl/fir_pkg.sv
// fir_pkg: constants and types shared by the fir engine and its capture sink.
package fir_pkg;

  // Capture sink run states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sink_state_e;

  // Byte distance between consecutive result words.
  localparam int WORD_STEP = 4;

  // Default number of result words in the result BRAM.
  localparam int RES_DEPTH_DEFAULT = 1024;

  // Data and address widths shared with the fir engine.
  localparam int FIR_DATA_WIDTH = 32;
  localparam int FIR_ADDR_WIDTH = 12;

endpackage

// File: rtl/fir_skid_fifo.sv
// fir_skid_fifo: 2-entry valid/ready buffer between the stream input and the
// BRAM writer. The caller guarantees no push when full and no pop when empty.
module fir_skid_fifo
  import fir_pkg::*;
#(
  parameter int WIDTH = FIR_DATA_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [1:0]       count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] slot_q [2];
  logic             wr_idx_q;
  logic             rd_idx_q;
  logic [1:0]       count_q;

  // Pointer and occupancy bookkeeping; reset discards any buffered samples.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_idx_q <= 1'b0;
      rd_idx_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) wr_idx_q <= ~wr_idx_q;
      if (pop_i)  rd_idx_q <= ~rd_idx_q;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sample storage; contents are only meaningful where count says so.
  always_ff @(posedge clk_i) begin
    if (push_i) slot_q[wr_idx_q] <= data_i;
  end

  assign count_o = count_q;
  assign head_o  = slot_q[rd_idx_q];

endmodule

// File: rtl/fir_stream_sink.sv
// fir_stream_sink: captures the fir output stream into the result BRAM at
// consecutive word addresses, checks tlast framing against data_length and
// gives a host read port priority over the writer.
// Optional feature macro: FIR_SINK_CHECKSUM_EN adds a running checksum output.
module fir_stream_sink
  import fir_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = FIR_ADDR_WIDTH,
  parameter int C_S_AXI_DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int RES_DEPTH          = RES_DEPTH_DEFAULT
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            start,
  input  logic [31:0]                     data_length,
  input  logic                            SM_tvalid,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   SM_tdata,
  input  logic                            SM_tlast,
  output logic                            SM_tready,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] Res_WE,
  output logic                            Res_EN,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   Res_Di,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   Res_A,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   Res_Do,
  input  logic                            rd_req,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   rd_addr,
  output logic                            rd_valid,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   rd_data,
  output logic                            busy,
  output logic                            done,
  output logic                            err_early_last,
  output logic                            err_missing_last,
  output logic                            err_overflow,
  output logic [31:0]                     sample_count
`ifdef FIR_SINK_CHECKSUM_EN
  ,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   checksum
`endif
);

  // Byte address of the last result word; the writer wraps to 0 after it.
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] LAST_ADDR =
    C_S_AXI_ADDR_WIDTH'((RES_DEPTH - 1) * WORD_STEP);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_STEP =
    C_S_AXI_ADDR_WIDTH'(WORD_STEP);

  sink_state_e state_q, state_d;

  logic [31:0]                   len_q;
  logic [31:0]                   acc_cnt_q;
  logic [C_S_AXI_ADDR_WIDTH-1:0] wptr_q;
  logic [31:0]                   sample_count_q;
  logic                          err_early_q;
  logic                          err_missing_q;
  logic                          err_overflow_q;
  logic                          rd_valid_q;

  logic [1:0]                    fifo_count;
  logic [C_S_AXI_DATA_WIDTH-1:0] fifo_head;
  logic                          accept;
  logic                          wr_fire;
  logic                          start_ok;
  logic [32:0]                   acc_next;
  logic [32:0]                   len_ext;
  logic                          count_reached;
  logic                          final_beat;

  assign start_ok      = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign accept        = SM_tvalid && SM_tready;
  // Compare in 33 bits so a data_length of 2^32-1 cannot wrap the count.
  assign acc_next      = {1'b0, acc_cnt_q} + 33'd1;
  assign len_ext       = {1'b0, len_q};
  assign count_reached = (acc_next >= len_ext);
  assign final_beat    = accept && (SM_tlast || count_reached);
  // Host reads own the BRAM port; the writer only runs on free cycles.
  assign wr_fire       = (fifo_count != 2'd0) && !rd_req;

  fir_skid_fifo #(
    .WIDTH (C_S_AXI_DATA_WIDTH)
  ) u_fifo (
    .clk_i   (ACLK),
    .rst_ni  (ARESET),
    .push_i  (accept),
    .data_i  (SM_tdata),
    .pop_i   (wr_fire),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  // State register.
  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; DRAIN ends as the last buffered sample is written so
  // that done appears the cycle after the final BRAM write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) state_d = (data_length == 32'd0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (final_beat) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_count == 2'd0 || (fifo_count == 2'd1 && wr_fire)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs; tready depends on registers only.
  always_comb begin
    busy      = (state_q == ST_RUN);
    done      = (state_q == ST_DONE);
    SM_tready = (state_q == ST_RUN) && (fifo_count != 2'd2);
  end

  // Run bookkeeping: length latch, accepted count, write pointer, error flags.
  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      len_q          <= 32'd0;
      acc_cnt_q      <= 32'd0;
      wptr_q         <= '0;
      sample_count_q <= 32'd0;
      err_early_q    <= 1'b0;
      err_missing_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else if (start_ok) begin
      len_q          <= data_length;
      acc_cnt_q      <= 32'd0;
      wptr_q         <= '0;
      sample_count_q <= 32'd0;
      err_early_q    <= 1'b0;
      err_missing_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      if (accept) begin
        acc_cnt_q <= acc_cnt_q + 32'd1;
        if (SM_tlast && !count_reached) err_early_q <= 1'b1;
        if (!SM_tlast && count_reached) err_missing_q <= 1'b1;
      end
      if (wr_fire) begin
        if (wptr_q == LAST_ADDR) begin
          wptr_q         <= '0;
          err_overflow_q <= 1'b1;
        end else begin
          wptr_q <= wptr_q + ADDR_STEP;
        end
        if (sample_count_q != 32'hFFFF_FFFF) sample_count_q <= sample_count_q + 32'd1;
      end
    end
  end

`ifdef FIR_SINK_CHECKSUM_EN
  logic [C_S_AXI_DATA_WIDTH-1:0] checksum_q;

  // Wrap-around sum of every sample as it is written to the BRAM.
  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET)      checksum_q <= '0;
    else if (start_ok) checksum_q <= '0;
    else if (wr_fire)  checksum_q <= checksum_q + fifo_head;
  end

  assign checksum = checksum_q;
`endif

  // Read response flag tracks the one-cycle BRAM read latency.
  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) rd_valid_q <= 1'b0;
    else         rd_valid_q <= rd_req;
  end

  assign Res_EN  = rd_req || wr_fire;
  assign Res_WE  = wr_fire ? '1 : '0;
  assign Res_A   = rd_req ? rd_addr : wptr_q;
  assign Res_Di  = wr_fire ? fifo_head : '0;

  assign rd_valid         = rd_valid_q;
  assign rd_data          = rd_valid_q ? Res_Do : '0;
  assign sample_count     = sample_count_q;
  assign err_early_last   = err_early_q;
  assign err_missing_last = err_missing_q;
  assign err_overflow     = err_overflow_q;

endmodule

// File: tb/tb_fir_stream_sink.sv
// tb_fir_stream_sink: directed checks of the capture sink against a small
// result-BRAM model with 1-cycle read latency. RES_DEPTH is 8 so overflow is
// reachable with a short run.
module tb_fir_stream_sink;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b0;
  logic        start = 1'b0;
  logic [31:0] data_length = 32'd0;
  logic        SM_tvalid = 1'b0;
  logic [31:0] SM_tdata = 32'd0;
  logic        SM_tlast = 1'b0;
  logic        SM_tready;
  logic [3:0]  Res_WE;
  logic        Res_EN;
  logic [31:0] Res_Di;
  logic [11:0] Res_A;
  logic [31:0] Res_Do = 32'd0;
  logic        rd_req = 1'b0;
  logic [11:0] rd_addr = 12'd0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;
  logic        err_early_last;
  logic        err_missing_last;
  logic        err_overflow;
  logic [31:0] sample_count;
`ifdef FIR_SINK_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  fir_stream_sink #(
    .C_S_AXI_ADDR_WIDTH (12),
    .C_S_AXI_DATA_WIDTH (32),
    .RES_DEPTH          (8)
  ) dut (
    .ACLK             (ACLK),
    .ARESET           (ARESET),
    .start            (start),
    .data_length      (data_length),
    .SM_tvalid        (SM_tvalid),
    .SM_tdata         (SM_tdata),
    .SM_tlast         (SM_tlast),
    .SM_tready        (SM_tready),
    .Res_WE           (Res_WE),
    .Res_EN           (Res_EN),
    .Res_Di           (Res_Di),
    .Res_A            (Res_A),
    .Res_Do           (Res_Do),
    .rd_req           (rd_req),
    .rd_addr          (rd_addr),
    .rd_valid         (rd_valid),
    .rd_data          (rd_data),
    .busy             (busy),
    .done             (done),
    .err_early_last   (err_early_last),
    .err_missing_last (err_missing_last),
    .err_overflow     (err_overflow),
    .sample_count     (sample_count)
`ifdef FIR_SINK_CHECKSUM_EN
    ,
    .checksum         (checksum)
`endif
  );

  always #5 ACLK = ~ACLK;

  // Result BRAM model: word-addressed, read-first, 1-cycle read latency.
  logic [31:0] mem [0:1023];
  always @(posedge ACLK) begin
    if (Res_EN) begin
      if (Res_WE == 4'hF) mem[Res_A[11:2]] <= Res_Di;
      Res_Do <= mem[Res_A[11:2]];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic start_run(input logic [31:0] len);
    start = 1'b1;
    data_length = len;
    tick();
    start = 1'b0;
  endtask

  // Present one beat and hold it until the edge that accepts it.
  task automatic send(input logic [31:0] d, input logic last);
    int n;
    n = 0;
    SM_tvalid = 1'b1;
    SM_tdata  = d;
    SM_tlast  = last;
    while (!SM_tready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check_eq("send_timeout", 32'd1, 32'd0);
    tick();
    SM_tvalid = 1'b0;
    SM_tlast  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    check_eq(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;

    // Reset state.
    #1;
    check_eq("rst_tready", {31'd0, SM_tready}, 32'd0);
    check_eq("rst_res_en", {31'd0, Res_EN}, 32'd0);
    check_eq("rst_res_we", {28'd0, Res_WE}, 32'd0);
    check_eq("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check_eq("rst_errs", {29'd0, err_early_last, err_missing_last, err_overflow}, 32'd0);
    check_eq("rst_count", sample_count, 32'd0);
    tick();
    ARESET = 1'b1;
    tick();

    // Run 1: five samples, tlast on the fifth.
    start_run(32'd5);
    check_eq("r1_busy", {31'd0, busy}, 32'd1);
    for (int i = 1; i <= 5; i++) send(32'(i), i == 5);
    check_eq("r1_final_we", {28'd0, Res_WE}, 32'h0000_000F);
    check_eq("r1_final_addr", {20'd0, Res_A}, 32'h0000_0010);
    check_eq("r1_done_early", {31'd0, done}, 32'd0);
    tick();
    check_eq("r1_done_next", {31'd0, done}, 32'd1);
    wait_done("r1_done");
    for (int i = 0; i < 5; i++) check_eq($sformatf("r1_word%0d", i), mem[i], 32'(i + 1));
    check_eq("r1_count", sample_count, 32'd5);
    check_eq("r1_errs", {29'd0, err_early_last, err_missing_last, err_overflow}, 32'd0);
`ifdef FIR_SINK_CHECKSUM_EN
    check_eq("r1_checksum", checksum, 32'd15);
`endif
    rd_req = 1'b1;
    rd_addr = 12'h008;
    tick();
    rd_req = 1'b0;
    check_eq("r1_rd_valid", {31'd0, rd_valid}, 32'd1);
    check_eq("r1_rd_data", rd_data, 32'd3);
    tick();
    check_eq("r1_rd_idle", rd_data, 32'd0);

    // Run 2: length 4, tlast on the second sample; a start during RUN is ignored.
    start_run(32'd4);
    start_run(32'd0);
    check_eq("r2_start_ignored", {31'd0, busy}, 32'd1);
    send(32'd7, 1'b0);
    send(32'd9, 1'b1);
    wait_done("r2_done");
    check_eq("r2_word0", mem[0], 32'd7);
    check_eq("r2_word1", mem[1], 32'd9);
    check_eq("r2_word2_kept", mem[2], 32'd3);
    check_eq("r2_count", sample_count, 32'd2);
    check_eq("r2_early", {31'd0, err_early_last}, 32'd1);
    check_eq("r2_missing", {31'd0, err_missing_last}, 32'd0);

    // Run 3: length 3, no tlast; a fourth beat must not be taken.
    start_run(32'd3);
    send(32'd10, 1'b0);
    send(32'd11, 1'b0);
    send(32'd12, 1'b0);
    SM_tvalid = 1'b1;
    SM_tdata  = 32'd13;
    check_eq("r3_tready_off", {31'd0, SM_tready}, 32'd0);
    wait_done("r3_done");
    check_eq("r3_tready_done", {31'd0, SM_tready}, 32'd0);
    SM_tvalid = 1'b0;
    check_eq("r3_missing", {31'd0, err_missing_last}, 32'd1);
    check_eq("r3_early", {31'd0, err_early_last}, 32'd0);
    check_eq("r3_count", sample_count, 32'd3);
    check_eq("r3_word2", mem[2], 32'd12);
    check_eq("r3_word3_kept", mem[3], 32'd4);

    // Run 4: continuous stream while a host read holds the port 3 cycles.
    start_run(32'd6);
    fork
      begin
        for (int i = 0; i < 6; i++) send(32'(21 + i), i == 5);
      end
      begin
        tick();
        tick();
        tick();
        rd_req  = 1'b1;
        rd_addr = 12'h000;
        for (int k = 0; k < 3; k++) begin
          tick();
          check_eq($sformatf("r4_rd%0d", k), rd_data, 32'd21);
          if (k == 1) check_eq("r4_tready_stall", {31'd0, SM_tready}, 32'd0);
        end
        rd_req = 1'b0;
      end
    join
    wait_done("r4_done");
    for (int i = 0; i < 6; i++) check_eq($sformatf("r4_word%0d", i), mem[i], 32'(21 + i));
    check_eq("r4_count", sample_count, 32'd6);
    check_eq("r4_errs", {29'd0, err_early_last, err_missing_last, err_overflow}, 32'd0);

    // Run 5: ten samples into an 8-word buffer wraps onto words 0 and 1.
    start_run(32'd10);
    for (int i = 0; i < 10; i++) send(32'(31 + i), i == 9);
    wait_done("r5_done");
    check_eq("r5_word0", mem[0], 32'd39);
    check_eq("r5_word1", mem[1], 32'd40);
    check_eq("r5_word2", mem[2], 32'd33);
    check_eq("r5_word7", mem[7], 32'd38);
    check_eq("r5_overflow", {31'd0, err_overflow}, 32'd1);
    check_eq("r5_count", sample_count, 32'd10);
`ifdef FIR_SINK_CHECKSUM_EN
    check_eq("r5_checksum", checksum, 32'd355);
`endif

    // Run 6: reset in the middle of a run, then a zero-length start.
    start_run(32'd5);
    send(32'd50, 1'b0);
    send(32'd51, 1'b0);
    #2;
    ARESET = 1'b0;
    #1;
    check_eq("r6_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("r6_rst_count", sample_count, 32'd0);
    check_eq("r6_rst_res_en", {31'd0, Res_EN}, 32'd0);
    check_eq("r6_rst_tready", {31'd0, SM_tready}, 32'd0);
    tick();
    ARESET = 1'b1;
    tick();
    start_run(32'd0);
    check_eq("r6_zero_done", {31'd0, done}, 32'd1);
    check_eq("r6_zero_tready", {31'd0, SM_tready}, 32'd0);
    tick();
    check_eq("r6_zero_hold", {30'd0, done, SM_tready}, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
